// File: rtl/data_mem_ctrl.sv
// Sequencer between the load/store datapath and the async latch-based data memory; optional DATA_MEM_CTRL_STATS_EN adds op counters.
// Latency: handshake at edge N -> rsp_valid in cycle N+3+WAIT_CYCLES for loads and stores; one op per 4+WAIT_CYCLES cycles.
// Backpressure: req_ready is high only in IDLE; req_* are sampled on the handshake edge alone and ignored otherwise.
module data_mem_ctrl #(
    parameter int D_ADDR_W    = 12,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [D_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy,
    output logic [D_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic                mem_oe,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef DATA_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_SETUP = 3'd1;
    localparam logic [2:0] S_W_PULSE = 3'd2;
    localparam logic [2:0] S_R_OE    = 3'd3;
    localparam logic [2:0] S_R_CAP   = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
            $error("data_mem_ctrl: WAIT_CYCLES must be within 0..15");
        end
    endgenerate

    logic [2:0] state;
    logic [3:0] wait_cnt;

    // Every output is a flop updated on the transition into the state that owns it,
    // so mem_we/mem_oe are glitch-free and no req_* input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        mem_addr  <= req_addr;
                        wait_cnt  <= WAIT_LD;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_write) begin
                            mem_wdata <= req_wdata;
                            state     <= S_W_SETUP;
                        end else begin
                            mem_oe <= 1'b1;
                            state  <= S_R_OE;
                        end
                    end
                end
                S_W_SETUP: begin
                    mem_we   <= 1'b1;
                    wait_cnt <= WAIT_LD;
                    state    <= S_W_PULSE;
                end
                S_W_PULSE: begin
                    if (wait_cnt == 4'd0) begin
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_R_OE: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_R_CAP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_R_CAP: begin
                    rsp_rdata <= mem_rdata;
                    mem_oe    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    mem_we    <= 1'b0;
                    mem_oe    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DATA_MEM_CTRL_STATS_EN
    // Counted on entry to RESP so the new value is visible during the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (state == S_W_PULSE && wait_cnt == 4'd0 && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (state == S_R_CAP && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with WAIT_CYCLES=0 and one with WAIT_CYCLES=3,
// each backed by a simple behavioural memory.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [11:0] req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_rdata [2];
    logic        busy      [2];
    logic [11:0] mem_addr  [2];
    logic [7:0]  mem_wdata [2];
    logic        mem_we    [2];
    logic        mem_oe    [2];
    wire  [7:0]  mem_rdata0;
    wire  [7:0]  mem_rdata1;
`ifdef DATA_MEM_CTRL_STATS_EN
    logic [15:0] rd_count  [2];
    logic [15:0] wr_count  [2];
`endif

    logic [7:0] mem0 [4096];
    logic [7:0] mem1 [4096];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.D_ADDR_W(12), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
        .mem_oe(mem_oe[0]), .mem_rdata(mem_rdata0)
`ifdef DATA_MEM_CTRL_STATS_EN
        , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
    );

    data_mem_ctrl #(.D_ADDR_W(12), .DATA_W(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
        .mem_oe(mem_oe[1]), .mem_rdata(mem_rdata1)
`ifdef DATA_MEM_CTRL_STATS_EN
        , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
    );

    // Read bus shows a distinctive junk value whenever output-enable is low.
    assign mem_rdata0 = mem_oe[0] ? mem0[mem_addr[0]] : 8'hEE;
    assign mem_rdata1 = mem_oe[1] ? mem1[mem_addr[1]] : 8'hEE;

    always @(negedge clk) begin
        if (mem_we[0]) mem0[mem_addr[0]] = mem_wdata[0];
        if (mem_we[1]) mem1[mem_addr[1]] = mem_wdata[1];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input int sel, input string tag);
        chk_eq({tag, "_ready"}, 32'(req_ready[sel]), 32'd1);
        chk_eq({tag, "_rsp_valid"}, 32'(rsp_valid[sel]), 32'd0);
        chk_eq({tag, "_rsp_rdata"}, 32'(rsp_rdata[sel]), 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy[sel]), 32'd0);
        chk_eq({tag, "_addr"}, 32'(mem_addr[sel]), 32'd0);
        chk_eq({tag, "_wdata"}, 32'(mem_wdata[sel]), 32'd0);
        chk_eq({tag, "_we"}, 32'(mem_we[sel]), 32'd0);
        chk_eq({tag, "_oe"}, 32'(mem_oe[sel]), 32'd0);
    endtask

    // One complete op; cycle 1 is the cycle right after the handshake edge N.
    task automatic run_op(input int sel, input logic wr, input logic [11:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rdata, input int w);
        int cyc = 0, rsp_cyc = 0, first_we = 0, n_we = 0, first_oe = 0, n_oe = 0;
        logic bad_bus = 1'b0, bad_excl = 1'b0;
        logic [7:0] held_wdata;
        held_wdata = mem_wdata[sel];
        @(posedge clk); #1;
        chk_eq("pre_ready", 32'(req_ready[sel]), 32'd1);
        req_valid[sel] = 1'b1; req_write[sel] = wr; req_addr[sel] = addr; req_wdata[sel] = wdata;
        @(posedge clk); #1;
        req_valid[sel] = 1'b0; req_write[sel] = ~wr; req_addr[sel] = ~addr; req_wdata[sel] = ~wdata;
        while (cyc < 25 && rsp_cyc == 0) begin
            @(negedge clk);
            cyc++;
            if (mem_we[sel]) begin
                if (first_we == 0) first_we = cyc;
                n_we++;
            end
            if (mem_oe[sel]) begin
                if (first_oe == 0) first_oe = cyc;
                n_oe++;
            end
            if (mem_we[sel] && mem_oe[sel]) bad_excl = 1'b1;
            if (mem_addr[sel] != addr || mem_wdata[sel] != (wr ? wdata : held_wdata)) bad_bus = 1'b1;
            if (rsp_valid[sel]) rsp_cyc = cyc;
        end
        chk_eq(wr ? "st_rsp_cycle" : "ld_rsp_cycle", 32'(rsp_cyc), 32'(3 + w));
        chk_eq("bus_stable", 32'(bad_bus), 32'd0);
        chk_eq("we_oe_exclusive", 32'(bad_excl), 32'd0);
        chk_eq(wr ? "st_rdata_held" : "ld_rdata", 32'(rsp_rdata[sel]), 32'(exp_rdata));
        if (wr) begin
            chk_eq("we_first_cycle", 32'(first_we), 32'd2);
            chk_eq("we_width", 32'(n_we), 32'(1 + w));
            chk_eq("st_no_oe", 32'(n_oe), 32'd0);
        end else begin
            chk_eq("oe_first_cycle", 32'(first_oe), 32'd1);
            chk_eq("oe_width", 32'(n_oe), 32'(2 + w));
            chk_eq("ld_no_we", 32'(n_we), 32'd0);
        end
        @(negedge clk);
        chk_eq("post_rsp_low", 32'(rsp_valid[sel]), 32'd0);
        chk_eq("post_ready", 32'(req_ready[sel]), 32'd1);
        chk_eq("post_addr_hold", 32'(mem_addr[sel]), 32'(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        int rsp_at;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
        end
        for (int a = 0; a < 4096; a++) begin
            mem0[a] = 8'h00; mem1[a] = 8'h00;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals(0, "rst0");
        chk_reset_vals(1, "rst3");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals(0, "idle0");

        run_op(0, 1'b1, 12'h0A5, 8'h3C, 8'h00, 0);
        run_op(0, 1'b0, 12'h0A5, 8'h00, 8'h3C, 0);
        run_op(1, 1'b1, 12'hFFF, 8'hA5, 8'h00, 3);
        run_op(1, 1'b0, 12'hFFF, 8'h00, 8'hA5, 3);
        run_op(1, 1'b1, 12'h010, 8'h77, 8'hA5, 3);

        // Back-to-back: req_valid held high, req_* changed during the first op.
        bad = 1'b0; rsp_at = 0;
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 12'h111; req_wdata[0] = 8'h11;
        @(posedge clk); #1;
        req_write[0] = 1'b0; req_addr[0] = 12'h0A5; req_wdata[0] = 8'h99;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (mem_addr[0] != 12'h111 || mem_wdata[0] != 8'h11 || req_ready[0]) bad = 1'b1;
            if (rsp_valid[0]) rsp_at = c;
        end
        chk_eq("b2b_first_hold", 32'(bad), 32'd0);
        chk_eq("b2b_first_rsp", 32'(rsp_at), 32'd3);
        @(negedge clk);
        chk_eq("b2b_idle_ready", 32'(req_ready[0]), 32'd1);
        chk_eq("b2b_idle_addr", 32'(mem_addr[0]), 32'h111);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk_eq("b2b_second_addr", 32'(mem_addr[0]), 32'h0A5);
        chk_eq("b2b_second_wdata", 32'(mem_wdata[0]), 32'h11);
        chk_eq("b2b_second_busy", 32'(busy[0]), 32'd1);
        rsp_at = 0;
        for (int c = 6; c <= 20 && rsp_at == 0; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) rsp_at = c;
        end
        chk_eq("b2b_second_rsp", 32'(rsp_at), 32'd7);
        chk_eq("b2b_second_rdata", 32'(rsp_rdata[0]), 32'h3C);
        @(negedge clk);

        // Asynchronous reset in the middle of a WAIT_CYCLES=3 write pulse.
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 12'h020; req_wdata[1] = 8'h5A;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("arst_we_before", 32'(mem_we[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals(1, "arst3");
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid[1] || mem_we[1]) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1] || busy[1] || mem_we[1]) bad = 1'b1;
        end
        chk_eq("arst_no_rsp", 32'(bad), 32'd0);
        chk_eq("arst_idle_ready", 32'(req_ready[1]), 32'd1);
        run_op(1, 1'b0, 12'hFFF, 8'h00, 8'hA5, 3);

`ifdef DATA_MEM_CTRL_STATS_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_eq("stats_rst_wr", 32'(wr_count[0]), 32'd0);
        chk_eq("stats_rst_rd", 32'(rd_count[0]), 32'd0);
        run_op(0, 1'b1, 12'h001, 8'h01, 8'h00, 0);
        run_op(0, 1'b1, 12'h002, 8'h02, 8'h00, 0);
        run_op(0, 1'b1, 12'h003, 8'h03, 8'h00, 0);
        run_op(0, 1'b0, 12'h001, 8'h00, 8'h01, 0);
        run_op(0, 1'b0, 12'h003, 8'h00, 8'h03, 0);
        chk_eq("stats_wr_count", 32'(wr_count[0]), 32'd3);
        chk_eq("stats_rd_count", 32'(rd_count[0]), 32'd2);
        force dut0.wr_count = 16'hFFFF;
        @(negedge clk);
        release dut0.wr_count;
        run_op(0, 1'b1, 12'h004, 8'h04, 8'h03, 0);
        chk_eq("stats_wr_saturate", 32'(wr_count[0]), 32'hFFFF);
        chk_eq("stats_rd_unchanged", 32'(rd_count[0]), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sequencer between the CPU load/store datapath and the asynchronous, latch-based data memory.
- Accepts one load/store request through a valid/ready handshake and registers address and data.
- Generates a glitch-free write-enable pulse with address/data setup and hold, or an output-enable window with registered read-data capture.
- Returns a single-cycle response to the requester.

Parameters:
- D_ADDR_W, 12, data address width.
- DATA_W, 8, data word width.
- WAIT_CYCLES, 0, extra cycles added to the write pulse and the read-enable window; range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  D_ADDR_W  request address
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_W  load data, valid when rsp_valid && last op was a load
- busy  output  1  state != IDLE
- mem_addr  output  D_ADDR_W  to memory data_addr
- mem_wdata  output  DATA_W  to memory write_data
- mem_we  output  1  to memory write_enable
- mem_oe  output  1  to memory output_enable
- mem_rdata  input  DATA_W  from memory tri-state read bus

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low; deassertion is released synchronously upstream.
- Reset values:
  - State = IDLE.
  - req_ready=1; rsp_valid=0; rsp_rdata=0; busy=0.
  - mem_addr=0; mem_wdata=0; mem_we=0; mem_oe=0.
  - Wait counter = 0.
- All outputs are registered; no combinational path from req_* to mem_* or rsp_*.
- States: IDLE, W_SETUP, W_PULSE, R_OE, R_CAP, RESP.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid && req_ready at edge N: mem_addr <= req_addr; mem_wdata <= req_wdata when req_write, otherwise held.
  - Latch op type; go to W_SETUP (write) or R_OE (read).
  - req_* are ignored outside the handshake edge.
- Write path:
  - W_SETUP, 1 cycle: mem_we=0, address/data stable. Next state W_PULSE with counter loaded to WAIT_CYCLES.
  - W_PULSE: mem_we=1 for 1+WAIT_CYCLES cycles; the counter decrements each cycle, exit at 0 to RESP.
  - RESP (write): mem_we=0, mem_addr/mem_wdata unchanged (hold), rsp_valid=1, rsp_rdata unchanged.
- Read path:
  - R_OE: mem_oe=1 for 1+WAIT_CYCLES cycles, then R_CAP.
  - R_CAP: mem_oe=1, 1 cycle; rsp_rdata <= mem_rdata at the end of this cycle.
  - RESP (read): mem_oe=0, rsp_valid=1, rsp_rdata = captured value.
- RESP always lasts exactly 1 cycle, then IDLE. req_ready=0 in every state except IDLE.
- Latency (WAIT_CYCLES=W):
  - Handshake at edge N gives rsp_valid high during cycle N+3+W for both load and store.
  - Maximum throughput is one op per 4+W cycles.
- Invariants:
  - mem_we && mem_oe is never true.
  - mem_we is never 1 in the cycle mem_addr or mem_wdata changes.
  - mem_addr/mem_wdata hold their last value in IDLE; they are not cleared after an op.
- rsp_rdata is held between responses; stores do not modify it.
- busy = (state != IDLE).
- Reset mid-operation:
  - All outputs return to reset values immediately (asynchronous), including mem_we=0.
  - No response is generated for the aborted request.
  - Memory content at the aborted address is undefined if reset hits in W_PULSE.
- WAIT_CYCLES above 15 is a parameter error; flag it with an elaboration-time assertion.

Optional Feature:
- Macro: DATA_MEM_CTRL_STATS_EN.
- With the macro defined:
  - Add outputs rd_count (16) and wr_count (16).
  - Each increments by 1 in the RESP cycle of the matching op and saturates at 16'hFFFF.
  - Both reset to 0 on rst_n.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> all outputs at reset values, req_ready=1, mem_we=mem_oe=0.
- Store then load, WAIT_CYCLES=0:
  - Store addr 12'h0A5, data 8'h3C -> mem_we high exactly 1 cycle (N+2) with addr/data stable in N+1..N+3, rsp_valid at N+3.
  - Load 12'h0A5 -> mem_oe high N+1..N+2, rsp_valid at N+3 with rsp_rdata=8'h3C.
- WAIT_CYCLES=3:
  - Store 12'hFFF/8'hA5 -> mem_we high 4 cycles, rsp_valid at N+6.
  - Load back -> rsp_rdata=8'hA5 at N+6.
- Back-to-back requests with req_valid held high and req_* changed mid-op:
  - Second request is accepted only in the IDLE cycle after RESP.
  - Mid-op changes on req_* have no effect on mem_addr/mem_wdata.
- Async reset asserted during W_PULSE -> mem_we drops the same cycle without a clock edge, no rsp_valid, state IDLE after release.
- With DATA_MEM_CTRL_STATS_EN: 3 stores + 2 loads -> wr_count=3, rd_count=2; forcing wr_count to 16'hFFFF plus one store -> stays 16'hFFFF.
